// File: rtl/rl_pair_pipeline_arbiter.sv
// rtl/rl_pair_pipeline_arbiter.sv - round-robin sharing of one pair-force pipeline with source tagging
module rl_pair_pipeline_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int REQ_ID_WIDTH = 2,
    parameter int PIPE_LATENCY = 17,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r2,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dx,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dz,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          r2_valid,
    output logic [DATA_WIDTH-1:0]         r2,
    output logic [DATA_WIDTH-1:0]         dx,
    output logic [DATA_WIDTH-1:0]         dy,
    output logic [DATA_WIDTH-1:0]         dz,
    input  logic [DATA_WIDTH-1:0]         RL_Force_X,
    input  logic [DATA_WIDTH-1:0]         RL_Force_Y,
    input  logic [DATA_WIDTH-1:0]         RL_Force_Z,
    input  logic                          RL_force_valid,
    output logic                          force_valid,
    output logic [DATA_WIDTH-1:0]         force_x,
    output logic [DATA_WIDTH-1:0]         force_y,
    output logic [DATA_WIDTH-1:0]         force_z,
    output logic [REQ_ID_WIDTH-1:0]       force_src_id,
    output logic [CNT_WIDTH-1:0]          inflight,
    output logic                          idle,
    output logic                          align_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [REQ_ID_WIDTH-1:0] rr_ptr;
    logic [REQ_ID_WIDTH-1:0] grant_id;
    logic                    grant_any;
    logic [REQ_ID_WIDTH-1:0] issue_id;

    // The registered issue stage ({r2_valid, issue_id}) feeds the delay line,
    // so the tail lines up with the cycle the pipeline returns the result.
    logic [PIPE_LATENCY-1:0] tag_v;
    logic [REQ_ID_WIDTH-1:0] tag_id [PIPE_LATENCY];
    logic                    tail_v;
    logic [REQ_ID_WIDTH-1:0] tail_id;

    assign tail_v  = tag_v[PIPE_LATENCY-1];
    assign tail_id = tag_id[PIPE_LATENCY-1];

    // Round-robin search starting just past the last granted requester
    always_comb begin
        int idx;
        req_ready = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (issue_en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = REQ_ID_WIDTH'(idx);
                end
            end
        end
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Issue stage: register the granted pair onto the pipeline input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2       <= '0;
            dx       <= '0;
            dy       <= '0;
            dz       <= '0;
            issue_id <= '0;
            rr_ptr   <= REQ_ID_WIDTH'(NUM_REQ - 1);
        end else begin
            r2_valid <= grant_any;
            if (grant_any) begin
                rr_ptr   <= grant_id;
                issue_id <= grant_id;
                r2       <= req_r2[grant_id*DATA_WIDTH +: DATA_WIDTH];
                dx       <= req_dx[grant_id*DATA_WIDTH +: DATA_WIDTH];
                dy       <= req_dy[grant_id*DATA_WIDTH +: DATA_WIDTH];
                dz       <= req_dz[grant_id*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Tag delay line carrying the requester ID alongside the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[PIPE_LATENCY-2:0], r2_valid};
            tag_id[0] <= issue_id;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Result stage: label returned forces and flag any tag/result disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            force_valid  <= 1'b0;
            force_x      <= '0;
            force_y      <= '0;
            force_z      <= '0;
            force_src_id <= '0;
            align_err    <= 1'b0;
        end else begin
            force_valid  <= RL_force_valid & tail_v;
            force_x      <= RL_Force_X;
            force_y      <= RL_Force_Y;
            force_z      <= RL_Force_Z;
            force_src_id <= tail_id;
            if (tail_v != RL_force_valid) begin
                align_err <= 1'b1;
            end
        end
    end

    // In-flight count: up on grant, down when a tag leaves the line, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({grant_any, tail_v})
                2'b10: if (inflight != CNT_MAX) inflight <= inflight + 1'b1;
                2'b01: if (inflight != '0)      inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (inflight == '0) && !r2_valid;

endmodule

// File: doc/rl_pair_pipeline_arbiter.md
Name: rl_pair_pipeline_arbiter

Overview:
- Shares one RL_Evaluate_Pairs_1st_Order_v2 force pipeline among NUM_REQ pair-filter requesters using round-robin arbitration.
- Registers the granted pair (r2, dx, dy, dz) onto the pipeline input.
- Carries the requester ID through a tag delay line matched to the pipeline latency, so every returned force is labelled with its source.
- Provides issue gating, in-flight tracking, idle indication and a sticky alignment-error flag for the force-accumulation controller.

Parameters:
- DATA_WIDTH, 32, IEEE-754 single word width.
- NUM_REQ, 4, number of requesters.
- REQ_ID_WIDTH, 2, log2(NUM_REQ).
- PIPE_LATENCY, 17, cycles from r2_valid to RL_force_valid in the force pipeline.
- CNT_WIDTH, 5, in-flight counter width; must hold PIPE_LATENCY+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_en  in  1  enables new grants when high
- req_valid  in  NUM_REQ  per-requester pair valid
- req_r2  in  NUM_REQ*DATA_WIDTH  flattened r2; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_dx, req_dy, req_dz  in  NUM_REQ*DATA_WIDTH  flattened displacements, same packing
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
- r2_valid  out  1  to pipeline
- r2, dx, dy, dz  out  DATA_WIDTH  to pipeline
- RL_Force_X, RL_Force_Y, RL_Force_Z  in  DATA_WIDTH  from pipeline
- RL_force_valid  in  1  from pipeline
- force_valid  out  1  tagged result valid
- force_x, force_y, force_z  out  DATA_WIDTH  tagged result
- force_src_id  out  REQ_ID_WIDTH  requester that produced the result
- inflight  out  CNT_WIDTH  pairs issued but not yet returned
- idle  out  1  inflight==0 & r2_valid==0
- align_err  out  1  sticky tag/result misalignment

Behaviour:
- Reset (async, rst=1): all outputs 0, rr_ptr=NUM_REQ-1, tag line cleared, align_err=0. Reset mid-operation discards all in-flight tags. The pipeline shares rst, so no stale results are expected.
- Arbitration (combinational req_ready):
  - If issue_en=0, req_ready=0.
  - Otherwise search req_valid starting at index (rr_ptr+1) mod NUM_REQ; grant the first set bit. At most one req_ready bit is high.
  - req_ready is never asserted for a requester whose req_valid is low.
- On grant of requester g:
  - rr_ptr<=g.
  - Next cycle: r2_valid=1 and r2/dx/dy/dz = requester g's words.
  - Tag line stage 0 gets {1, g}.
- With no grant, r2_valid<=0. Data outputs hold their last value (don't-care).
- Throughput: one pair per cycle, no bubbles while any req_valid is high and issue_en=1. All requesters continuously valid -> grants rotate 0,1,2,3,0...
- Tag line: PIPE_LATENCY-stage shift register of {tag_valid, id}, loaded in parallel with r2_valid. The tail aligns with RL_force_valid.
- Result stage (registered):
  - force_valid <= RL_force_valid & tail_valid.
  - force_x/y/z <= RL_Force_*.
  - force_src_id <= tail_id.
- Latency: handshake cycle T -> r2_valid at T+1 -> force_valid at T+1+PIPE_LATENCY+1 (T+19 by default).
- align_err: set when tail_valid != RL_force_valid in any cycle. Cleared only by rst. Results are still forwarded when force_valid conditions hold.
- inflight:
  - +1 on grant, -1 on tail_valid; both in the same cycle -> unchanged.
  - Saturates, never wraps. Maximum legal value is PIPE_LATENCY+1.
- Deasserting issue_en mid-stream: no new grants. In-flight pairs drain normally, and idle rises PIPE_LATENCY+1 cycles after the last r2_valid.
- Requester dropping req_valid while not granted: no effect, arbitration moves on.

Test Plan:
- Single request: req_valid=4'b0100, r2=0x41A80000, dx=0x3F800000, dy=0x40000000, dz=0x40800000 -> req_ready=4'b0100 at T, r2_valid at T+1 with those words, force_valid at T+19 with force_src_id=2, align_err=0.
- All four requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 back-to-back; 8 force_valid pulses on consecutive cycles with src ids 0,1,2,3,0,1,2,3; inflight peaks at 8.
- Fairness: requesters 1 and 3 held valid, last grant 3 -> next grants 1,3,1,3; requester 0 raises valid after a grant of 1 -> order becomes 3,0,1.
- issue_en=0 with req_valid=4'hF -> req_ready=0, r2_valid=0, idle=1. Raise issue_en -> first grant goes to (rr_ptr+1).
- Reset asserted while 5 pairs are in flight -> all outputs 0 immediately, inflight=0, no force_valid afterward until new grants.
- Inject RL_force_valid=1 with an empty tag line -> align_err=1, force_valid=0. align_err stays set until rst.
